// File: rtl/dram_uart_loader.sv
// UART-fed DRAM loader: receives a length-prefixed 8N1 byte stream and writes it
// to DRAM from address 0, holding the processor off the memory port meanwhile.
module dram_uart_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 8
) (
    input  logic              Clk,
    input  logic              RST,
    input  logic              start,
    input  logic              rx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wren,
    output logic              hold_proc,
    output logic              done,
    output logic              frame_err,
    output logic [ADDR_W:0]   byte_count
);

    localparam logic [1:0] R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3;
    localparam logic [1:0] L_IDLE = 2'd0, L_LEN = 2'd1, L_DATA = 2'd2, L_DONE = 2'd3;

    localparam logic [11:0]       BIT_LAST  = 12'(CLKS_PER_BIT - 1);
    localparam logic [11:0]       HALF_LAST = 12'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ADDR_W:0]   CNT_ONE   = 1;
    localparam logic [ADDR_W:0]   CNT_FULL  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;

    logic              rx_meta_p0, rx_sync_p1;
    logic [1:0]        r_state, l_state;
    logic [11:0]       clk_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        rx_shift, rx_byte;
    logic              rx_armed, byte_valid, frame_bad;
    logic [ADDR_W:0]   len_target;

    // A zero length byte means a full address space worth of data.
    function automatic logic [ADDR_W:0] len_decode(input logic [7:0] n);
        if (n == 8'd0) return CNT_FULL;
        return (ADDR_W+1)'(n);
    endfunction

    // Stage p0/p1: two-flop synchroniser, then the receiver FSM.
    always_ff @(posedge Clk) begin
        if (RST) begin
            rx_meta_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            r_state    <= R_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            rx_byte    <= '0;
            rx_armed   <= 1'b1;
            byte_valid <= 1'b0;
            frame_bad  <= 1'b0;
        end else begin
            rx_meta_p0 <= rx;
            rx_sync_p1 <= rx_meta_p0;
            byte_valid <= 1'b0;
            frame_bad  <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_armed) begin
                        if (rx_sync_p1) rx_armed <= 1'b1;
                    end else if (!rx_sync_p1) begin
                        r_state <= R_START;
                    end
                end
                R_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        r_state <= rx_sync_p1 ? R_IDLE : R_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 12'd1;
                    end
                end
                R_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt  <= '0;
                        rx_shift <= {rx_sync_p1, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) r_state <= R_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 12'd1;
                    end
                end
                default: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        r_state <= R_IDLE;
                        if (rx_sync_p1) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= rx_shift;
                        end else begin
                            // Wait for the line to return high before accepting a new start bit.
                            frame_bad <= 1'b1;
                            rx_armed  <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 12'd1;
                    end
                end
            endcase
        end
    end

    // Stage p2: loader FSM, write strobe and address counter.
    always_ff @(posedge Clk) begin
        if (RST) begin
            l_state    <= L_IDLE;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_wren   <= 1'b0;
            hold_proc  <= 1'b0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
            byte_count <= '0;
            len_target <= '0;
        end else begin
            mem_wren <= 1'b0;
            if (frame_bad) frame_err <= 1'b1;
            if (start) begin
                l_state    <= L_LEN;
                done       <= 1'b0;
                frame_err  <= 1'b0;
                byte_count <= '0;
                mem_addr   <= '0;
                hold_proc  <= 1'b1;
            end else begin
                case (l_state)
                    L_LEN: begin
                        if (byte_valid) begin
                            len_target <= len_decode(rx_byte);
                            l_state    <= L_DATA;
                        end
                    end
                    L_DATA: begin
                        if (byte_valid) begin
                            mem_wren <= 1'b1;
                            mem_data <= rx_byte;
                        end
                        if (mem_wren) begin
                            mem_addr   <= mem_addr + ADDR_ONE;
                            byte_count <= byte_count + CNT_ONE;
                            if (byte_count + CNT_ONE == len_target) begin
                                l_state   <= L_DONE;
                                hold_proc <= 1'b0;
                                done      <= 1'b1;
                            end
                        end
                    end
                    L_DONE:  l_state <= L_IDLE;
                    default: l_state <= L_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dram_uart_loader.sv
// Directed bench for dram_uart_loader: drives 8N1 frames at 4 clocks per bit
// and logs every DRAM write for comparison against hand-computed values.
module tb_dram_uart_loader;

    localparam int CPB = 4;
    localparam int AW  = 8;

    logic          Clk = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic          rx = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_wren;
    logic          hold_proc;
    logic          done;
    logic          frame_err;
    logic [AW:0]   byte_count;

    int total = 0;
    int bad   = 0;

    logic [7:0] wa [0:1023];
    logic [7:0] wd [0:1023];
    int         wr_n = 0;

    dram_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .Clk(Clk), .RST(RST), .start(start), .rx(rx),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .hold_proc(hold_proc), .done(done), .frame_err(frame_err),
        .byte_count(byte_count)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (mem_wren === 1'b1) begin
            wa[wr_n] <= mem_addr;
            wd[wr_n] <= mem_data;
            wr_n     <= wr_n + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        rx = 1'b1;
        tick(3);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        RST = 1'b1;
        rx  = 1'b1;
        tick(3);
        RST = 1'b0;
        total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h want=00", mem_addr); end
        total++; if (mem_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", mem_data); end
        total++; if (mem_wren !== 1'b0) begin bad++; $display("FAIL reset_wren got=%b want=0", mem_wren); end
        total++; if (hold_proc !== 1'b0) begin bad++; $display("FAIL reset_hold got=%b want=0", hold_proc); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", frame_err); end
        total++; if (byte_count !== 9'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", byte_count); end
        base = wr_n;
        tick(100);
        total++; if (wr_n - base !== 0) begin bad++; $display("FAIL reset_idle_writes got=%0d want=0", wr_n - base); end
    endtask

    task automatic test_basic();
        int base;
        logic [7:0] exp_d [3];
        exp_d = '{8'hA5, 8'h3C, 8'hFF};
        base = wr_n;
        pulse_start();
        total++; if (hold_proc !== 1'b1) begin bad++; $display("FAIL basic_hold_armed got=%b want=1", hold_proc); end
        send_byte(8'h03);
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'hFF);
        tick(4);
        total++; if (wr_n - base !== 3) begin bad++; $display("FAIL basic_nwrites got=%0d want=3", wr_n - base); end
        for (int i = 0; i < 3; i++) begin
            total++; if (wa[base+i] !== 8'(i)) begin bad++; $display("FAIL basic_addr%0d got=%h want=%h", i, wa[base+i], 8'(i)); end
            total++; if (wd[base+i] !== exp_d[i]) begin bad++; $display("FAIL basic_data%0d got=%h want=%h", i, wd[base+i], exp_d[i]); end
        end
        total++; if (byte_count !== 9'd3) begin bad++; $display("FAIL basic_count got=%0d want=3", byte_count); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b want=1", done); end
        total++; if (hold_proc !== 1'b0) begin bad++; $display("FAIL basic_hold got=%b want=0", hold_proc); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL basic_ferr got=%b want=0", frame_err); end
        total++; if (mem_addr !== 8'h03) begin bad++; $display("FAIL basic_addr_after got=%h want=03", mem_addr); end
    endtask

    task automatic test_bad_stop();
        int base;
        base = wr_n;
        pulse_start();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL badstop_done_clr got=%b want=0", done); end
        send_byte(8'h02);
        send_byte(8'h11, 1'b0);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL badstop_ferr_set got=%b want=1", frame_err); end
        send_byte(8'h22);
        send_byte(8'h33);
        tick(4);
        total++; if (wr_n - base !== 2) begin bad++; $display("FAIL badstop_nwrites got=%0d want=2", wr_n - base); end
        total++; if (wa[base] !== 8'h00 || wd[base] !== 8'h22) begin bad++; $display("FAIL badstop_w0 got=%h@%h want=22@00", wd[base], wa[base]); end
        total++; if (wa[base+1] !== 8'h01 || wd[base+1] !== 8'h33) begin bad++; $display("FAIL badstop_w1 got=%h@%h want=33@01", wd[base+1], wa[base+1]); end
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL badstop_ferr got=%b want=1", frame_err); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL badstop_done got=%b want=1", done); end
        total++; if (byte_count !== 9'd2) begin bad++; $display("FAIL badstop_count got=%0d want=2", byte_count); end
    endtask

    task automatic test_glitch_ignore();
        int base;
        base = wr_n;
        pulse_start();
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL glitch_ferr_clr got=%b want=0", frame_err); end
        tick(5);
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(30);
        total++; if (wr_n - base !== 0) begin bad++; $display("FAIL glitch_nwrites got=%0d want=0", wr_n - base); end
        total++; if (hold_proc !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL glitch_state got=hold%b/done%b want=hold1/done0", hold_proc, done); end
        send_byte(8'h01);
        send_byte(8'h44);
        tick(4);
        total++; if (wr_n - base !== 1) begin bad++; $display("FAIL glitch_len_nwrites got=%0d want=1", wr_n - base); end
        total++; if (wa[base] !== 8'h00 || wd[base] !== 8'h44) begin bad++; $display("FAIL glitch_w0 got=%h@%h want=44@00", wd[base], wa[base]); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL glitch_done got=%b want=1", done); end
        send_byte(8'h55);
        tick(6);
        total++; if (wr_n - base !== 1) begin bad++; $display("FAIL ignore_nwrites got=%0d want=1", wr_n - base); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ignore_done got=%b want=1", done); end
        total++; if (byte_count !== 9'd1) begin bad++; $display("FAIL ignore_count got=%0d want=1", byte_count); end
        total++; if (mem_data !== 8'h44) begin bad++; $display("FAIL ignore_data_hold got=%h want=44", mem_data); end
    endtask

    task automatic test_wrap();
        int base;
        base = wr_n;
        pulse_start();
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        tick(4);
        total++; if (wr_n - base !== 256) begin bad++; $display("FAIL wrap_nwrites got=%0d want=256", wr_n - base); end
        for (int i = 0; i < 256; i++) begin
            total++;
            if (wa[base+i] !== 8'(i) || wd[base+i] !== 8'(i)) begin
                bad++; $display("FAIL wrap_w%0d got=%h@%h want=%h@%h", i, wd[base+i], wa[base+i], 8'(i), 8'(i));
            end
        end
        total++; if (byte_count !== 9'd256) begin bad++; $display("FAIL wrap_count got=%0d want=256", byte_count); end
        total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL wrap_addr got=%h want=00", mem_addr); end
        total++; if (done !== 1'b1 || hold_proc !== 1'b0) begin bad++; $display("FAIL wrap_done got=done%b/hold%b want=done1/hold0", done, hold_proc); end
    endtask

    task automatic test_restart();
        int base;
        base = wr_n;
        pulse_start();
        send_byte(8'h05);
        send_byte(8'hAA);
        send_byte(8'hBB);
        tick(2);
        total++; if (wr_n - base !== 2) begin bad++; $display("FAIL restart_pre_nwrites got=%0d want=2", wr_n - base); end
        total++; if (byte_count !== 9'd2) begin bad++; $display("FAIL restart_pre_count got=%0d want=2", byte_count); end
        pulse_start();
        total++; if (byte_count !== 9'd0 || mem_addr !== 8'h00) begin bad++; $display("FAIL restart_clear got=cnt%0d/addr%h want=cnt0/addr00", byte_count, mem_addr); end
        total++; if (hold_proc !== 1'b1) begin bad++; $display("FAIL restart_hold got=%b want=1", hold_proc); end
        send_byte(8'h01);
        send_byte(8'h77);
        tick(4);
        total++; if (wr_n - base !== 3) begin bad++; $display("FAIL restart_nwrites got=%0d want=3", wr_n - base); end
        total++; if (wa[base+2] !== 8'h00 || wd[base+2] !== 8'h77) begin bad++; $display("FAIL restart_w got=%h@%h want=77@00", wd[base+2], wa[base+2]); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL restart_done got=%b want=1", done); end
        total++; if (byte_count !== 9'd1) begin bad++; $display("FAIL restart_count got=%0d want=1", byte_count); end
    endtask

    task automatic test_rst_mid();
        int base;
        base = wr_n;
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h9A);
        tick(1);
        total++; if (wr_n - base !== 1) begin bad++; $display("FAIL rstmid_pre_nwrites got=%0d want=1", wr_n - base); end
        RST = 1'b1;
        tick(1);
        total++; if (hold_proc !== 1'b0) begin bad++; $display("FAIL rstmid_hold got=%b want=0", hold_proc); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", done); end
        total++; if (byte_count !== 9'd0) begin bad++; $display("FAIL rstmid_count got=%0d want=0", byte_count); end
        RST = 1'b0;
        send_byte(8'h9B);
        send_byte(8'h9C);
        tick(4);
        total++; if (wr_n - base !== 1) begin bad++; $display("FAIL rstmid_nwrites got=%0d want=1", wr_n - base); end
        total++; if (done !== 1'b0 || hold_proc !== 1'b0) begin bad++; $display("FAIL rstmid_after got=done%b/hold%b want=done0/hold0", done, hold_proc); end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_bad_stop();
        test_glitch_ignore();
        test_wrap();
        test_restart();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_uart_loader.md
Name: dram_uart_loader

Overview:
- Upstream stage of the processor's data memory: receives a length-prefixed byte stream on a UART line and writes it into DRAM starting at address 0.
- A top-level mux hands the DRAM port to this block instead of the processor while hold_proc is high.
- Contains a UART receiver (oversampled, 8N1) and a loader FSM that drives the address counter and the write strobe.
- Releases the processor (deasserts hold_proc) once the programmed byte count has been written.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 4..4095
ADDR_W, 8, DRAM address width

Ports:
Clk  in  1  system clock, rising edge
RST  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; arms a new load
rx  in  1  asynchronous UART line, idles high
mem_addr  out  ADDR_W  DRAM write address
mem_data  out  8  DRAM write data
mem_wren  out  1  DRAM write enable, one-cycle pulse per byte
hold_proc  out  1  high while a load is armed or in progress; holds the processor in reset and selects this block on the DRAM port
done  out  1  high after a completed load, until the next start or RST
frame_err  out  1  sticky; set on a bad stop bit, cleared by start or RST
byte_count  out  ADDR_W+1  number of data bytes written in the current load

Behaviour:
- Reset (synchronous RST=1) forces:
  - mem_addr=0, mem_data=0, mem_wren=0, hold_proc=0, done=0, frame_err=0, byte_count=0.
  - Both FSMs go to idle; the rx synchroniser is set to 1.
  - RST mid-load aborts the load with no further writes.
- rx synchroniser: two flops; all logic uses only the synchronised value. This adds 2 cycles of latency.
- Receiver FSM, states R_IDLE, R_START, R_DATA, R_STOP:
  - R_IDLE: waits for synchronised rx=0.
  - R_START: counts CLKS_PER_BIT/2 cycles (integer division), then samples rx. If rx=1 the pulse was a glitch; return to R_IDLE. If rx=0, go to R_DATA.
  - R_DATA: samples every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - R_STOP: samples after CLKS_PER_BIT cycles.
    - Stop=1: byte_valid pulses for 1 cycle, carrying the byte.
    - Stop=0: frame_err is set, the byte is discarded, and the receiver waits in R_IDLE for rx=1 before re-arming.
- Loader FSM, states L_IDLE, L_LEN, L_DATA, L_DONE:
  - L_IDLE: on start, clear done, frame_err, byte_count and mem_addr; set hold_proc=1; go to L_LEN.
  - L_LEN: the first valid byte is the length N. N=0 means 256 bytes when ADDR_W=8; in general N=0 means 2^ADDR_W. Go to L_DATA.
  - L_DATA: on each valid byte:
    - The cycle after byte_valid: mem_data=byte, mem_addr=current address, mem_wren=1 for exactly 1 cycle.
    - The cycle after the write: address increments and byte_count increments.
    - When byte_count reaches N, go to L_DONE.
  - L_DONE: for one cycle, hold_proc=0 and done=1; then return to L_IDLE with done held.
- Bytes received in L_IDLE or L_DONE are ignored: no write, no count change.
- A start pulse while in L_LEN or L_DATA restarts the load from L_LEN with the address at 0.
- Address wrap: with N=2^ADDR_W, the last write goes to address 2^ADDR_W-1, then mem_addr wraps to 0. byte_count is ADDR_W+1 bits wide so it can hold 256.
- frame_err does not abort the load. The loader keeps waiting for the remaining good bytes; the host detects the error via frame_err and retransmits.
- mem_addr and mem_data hold their last values between writes.

Test Plan:
(All with CLKS_PER_BIT=4.)
- Reset: hold RST for 3 cycles with rx=1 -> all outputs 0; no mem_wren for 100 cycles.
- Basic load: start, then send 0x03, 0xA5, 0x3C, 0xFF -> three mem_wren pulses at addr 0, 1, 2 with data A5, 3C, FF; then byte_count=3, done=1, hold_proc=0, frame_err=0.
- Bad stop bit: start, send 0x02, then a 0x11 frame with stop=0, then 0x22, 0x33 -> frame_err=1; writes 22@0 and 33@1; done=1.
- Glitch and ignore: rx low for 1 cycle in L_LEN -> no byte, no state change. Sending 0x55 after done -> no write; done stays 1.
- Wrap and restart:
  - start, N=0, then 256 bytes of value i -> writes 0..255 to addr 0..255; byte_count=256; mem_addr=0 afterwards.
  - A separate run: start mid-L_DATA after 2 bytes, then 0x01, 0x77 -> write 77@0; done=1.
- RST mid-load: assert RST after the first data byte -> hold_proc=0 the next cycle, no further writes, done=0.
